gold_qpsk_sequence_gen: RTL
===========================

Name: gold_qpsk_sequence_gen

Overview:
- Parametrised successor to the PBCH DMRS generator.
- Produces length-LEN QPSK reference sequences from the 3GPP 38.211 Gold sequence (5.2.1), two bits per clock cycle.
- c_init is either computed internally (PBCH DMRS, 7.4.1.4.1) or supplied externally (PDSCH/PDCCH DMRS, scrambling).
- Output is an AXI-stream of mapped IQ samples with backpressure, feeding the channel estimator and descrambler.

Parameters:
- OUT_DW, 32, output sample width; I = tdata[OUT_DW/2-1:0], Q = tdata[OUT_DW-1:OUT_DW/2], each signed two's complement.
- LEN, 144, symbols per sequence (≥1).
- NC, 1600, Gold sequence offset Nc; must be even.
- AMP, 2**(OUT_DW/2-2), QPSK magnitude; must fit in OUT_DW/2 signed.
- MAX_CELL_ID, 1007, maximum N_id.

Ports:
- clk_i  in  1  clock
- reset_i  in  1  asynchronous, active-high reset
- start_i  in  1  one-cycle pulse; latches config and begins a sequence
- mode_i  in  1  0 = PBCH c_init from N_id_i/ibar_i; 1 = c_init_i used directly
- N_id_i  in  $clog2(MAX_CELL_ID)  cell ID, sampled on start_i
- ibar_i  in  3  ibar_SSB, sampled on start_i
- c_init_i  in  31  external c_init, sampled on start_i
- m_axis_out_tdata  out  OUT_DW  {Q, I}
- m_axis_out_tvalid  out  1  sample valid
- m_axis_out_tready  in  1  downstream ready
- m_axis_out_tlast  out  1  high on symbol LEN-1
- busy_o  out  1  high in WARMUP or RUN
- c_init_o  out  31  c_init currently in use (debug)

Behaviour:
- Reset (asynchronous, active-high), all outputs 0:
  - state IDLE, x1 = 0, x2 = 0.
  - tdata/tvalid/tlast/busy_o/c_init_o = 0.
- LFSR registers x1, x2 are 31 bits; bit k holds x(n+k).
- Two-step advance:
  - x1: new x(n+31) = x(n+3)^x(n); new x(n+32) = x(n+4)^x(n+1).
  - x2: new x(n+31) = x(n+3)^x(n+2)^x(n+1)^x(n); x(n+32) analogously, shifted by one.
  - Register shifts right by 2.
  - c(2m) = x1[0]^x2[0]; c(2m+1) = x1[1]^x2[1].
- PBCH c_init, computed in the start cycle:
  - c_init = ((ibar+1)*(N_id>>2)+... exactly: 2^11·(ibar+1)·(floor(N_id/4)+1) + 2^6·(ibar+1) + (N_id mod 4).
  - Intermediates are at least 31 bits wide; no truncation for N_id ≤ 1007, ibar ≤ 7.
- States:
  - IDLE:
    - tvalid = 0.
    - On start_i: load x1 = 31'd1, x2 = c_init, c_init_o = c_init, cnt = 0, busy_o = 1.
    - Go to WARMUP, or to RUN if NC == 0.
  - WARMUP:
    - Advance 2 per cycle for NC/2 cycles, then go to RUN.
    - WARMUP latency is NC/2 cycles (800 for the default NC).
  - RUN:
    - tvalid = 1.
    - tdata maps bit 0 → +AMP and bit 1 → −AMP: I from c(2m), Q from c(2m+1).
    - tlast = (cnt == LEN-1).
    - LFSRs advance and cnt increments only on tvalid & tready.
    - On the handshake with tlast: go to IDLE; tvalid, tlast and busy_o drop in the next cycle.
  - tdata is registered and driven from the current LFSR state; the first valid sample appears the cycle after WARMUP ends.
- AXI rules:
  - While tvalid & !tready, tdata and tlast are held stable.
  - tvalid never drops without a handshake, except on a restart or reset.
- start_i while busy: abort the current sequence and restart with the new config.
  - tvalid deasserts in the next cycle, and the partial sequence gets no tlast.
  - start_i coincident with the final handshake: the restart wins, with no idle cycle.
- Config inputs are ignored except in the start_i cycle.
- Reset mid-operation returns to IDLE immediately; nothing resumes.
- No internal throttling: with tready held high, LEN samples are sent in LEN consecutive cycles.

Test Plan:
- mode 1, c_init_i = 0, NC = 0 (test instance), LEN = 16, tready = 1:
  - symbol 0 = (I = −AMP, Q = +AMP); symbols 1–14 = (+AMP, +AMP); symbol 15 = (+AMP, −AMP) with tlast.
  - The first valid sample arrives 1 cycle after start_i.
- mode 0, N_id = 0, ibar = 0 → c_init_o = 0x840.
- mode 0, N_id = 1007, ibar = 2 → c_init_o = 0x17A0C3.
- For both PBCH cases, 144 symbols must match the Python 38.211 model bit-exactly, with the first tvalid 801 cycles after start_i.
- Random tready (50 %) over a default run:
  - exactly 144 handshakes, with the sequence identical to the tready = 1 run.
  - tdata/tlast stable whenever stalled; exactly one tlast.
- start_i at symbol 50 with a new N_id:
  - the old stream stops with no tlast; the new sequence restarts from WARMUP and matches the model for the new N_id.
- Assert reset_i during WARMUP and during RUN:
  - all outputs go to 0 asynchronously, the block stays IDLE afterwards, and a following start produces a correct full sequence.

Source files
------------

// File: rtl/gold_qpsk_sequence_gen_if.sv
// AXI-stream carrying mapped QPSK samples out of gold_qpsk_sequence_gen.
//   tdata  : {Q, I}, each OUT_DW/2 bits signed two's complement
//   tvalid : sample valid
//   tready : downstream ready
//   tlast  : final symbol of the sequence
// master = sequence generator, slave = consumer (channel estimator, descrambler).
interface gold_qpsk_sequence_gen_if #(
    parameter int OUT_DW = 32
);
    logic [OUT_DW-1:0] tdata;
    logic              tvalid;
    logic              tready;
    logic              tlast;

    modport master (output tdata, tvalid, tlast, input tready);
    modport slave  (input tdata, tvalid, tlast, output tready);
endinterface

// File: rtl/gold_qpsk_sequence_gen.sv
// Gold-sequence (x1/x2 LFSR pair) QPSK reference sequence generator, two
// sequence bits (one QPSK symbol) per clock.
//   clk_i, reset_i       : clock, asynchronous active-high reset
//   start_i              : one-cycle pulse; latches config, (re)starts a sequence
//   mode_i               : 0 = PBCH c_init from N_id_i/ibar_i, 1 = c_init_i
//   N_id_i, ibar_i       : PBCH cell ID / SSB index, sampled on start_i
//   c_init_i             : external c_init, sampled on start_i
//   m_axis_out           : AXI-stream master of {Q, I} samples, tlast on symbol LEN-1
//   busy_o               : sequence in warm-up or streaming
//   c_init_o             : c_init currently in use
module gold_qpsk_sequence_gen #(
    parameter int OUT_DW      = 32,
    parameter int LEN         = 144,
    parameter int NC          = 1600,
    parameter int AMP         = 2**(OUT_DW/2-2),
    parameter int MAX_CELL_ID = 1007
) (
    input  logic                           clk_i,
    input  logic                           reset_i,
    input  logic                           start_i,
    input  logic                           mode_i,
    input  logic [$clog2(MAX_CELL_ID)-1:0] N_id_i,
    input  logic [2:0]                     ibar_i,
    input  logic [30:0]                    c_init_i,
    gold_qpsk_sequence_gen_if.master       m_axis_out,
    output logic                           busy_o,
    output logic [30:0]                    c_init_o
);
    localparam int HW        = OUT_DW / 2;
    localparam int CW        = $clog2(LEN + 1);
    localparam int WW        = $clog2(NC / 2 + 2);
    localparam int WARM_LAST = (NC >= 2) ? NC / 2 - 1 : 0;
    localparam logic [HW-1:0] AMP_P = HW'(AMP);
    localparam logic [HW-1:0] AMP_N = HW'(-AMP);

    typedef enum logic [1:0] {IDLE, WARMUP, RUN} state_t;

    state_t            state_q, state_d;
    logic [30:0]       x1_q, x1_d, x2_q, x2_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [WW-1:0]     warm_q, warm_d;
    logic [30:0]       cinit_q, cinit_d;
    logic [OUT_DW-1:0] tdata_q, tdata_d;
    logic              tvalid_q, tvalid_d, tlast_q, tlast_d, busy_q;
    logic              hs;

    // Two-step advance: bit k holds x(n+k); after the shift new bits 29/30
    // are x(n+31)/x(n+32).
    function automatic logic [30:0] adv_x1(input logic [30:0] x);
        return {x[4] ^ x[1], x[3] ^ x[0], x[30:2]};
    endfunction

    function automatic logic [30:0] adv_x2(input logic [30:0] x);
        return {x[4] ^ x[3] ^ x[2] ^ x[1], x[3] ^ x[2] ^ x[1] ^ x[0], x[30:2]};
    endfunction

    // PBCH c_init; 31-bit intermediates never overflow for N_id <= 1007, ibar <= 7.
    logic [30:0] ib1, nq1, cinit_pbch, cinit_sel;
    always_comb begin
        ib1        = 31'(ibar_i) + 31'd1;
        nq1        = 31'(N_id_i >> 2) + 31'd1;
        cinit_pbch = ((ib1 * nq1) << 11) + (ib1 << 6) + 31'(N_id_i[1:0]);
        cinit_sel  = mode_i ? c_init_i : cinit_pbch;
    end

    assign hs = tvalid_q & m_axis_out.tready;

    always_comb begin
        state_d = state_q;
        x1_d    = x1_q;
        x2_d    = x2_q;
        cnt_d   = cnt_q;
        warm_d  = warm_q;
        cinit_d = cinit_q;
        // start_i wins over everything, including the final handshake.
        if (start_i) begin
            x1_d    = 31'd1;
            x2_d    = cinit_sel;
            cinit_d = cinit_sel;
            cnt_d   = '0;
            warm_d  = '0;
            state_d = (NC == 0) ? RUN : WARMUP;
        end else begin
            unique case (state_q)
                IDLE: state_d = IDLE;
                WARMUP: begin
                    x1_d   = adv_x1(x1_q);
                    x2_d   = adv_x2(x2_q);
                    warm_d = warm_q + 1'b1;
                    if (warm_q == WW'(WARM_LAST)) state_d = RUN;
                end
                RUN: begin
                    if (hs) begin
                        x1_d = adv_x1(x1_q);
                        x2_d = adv_x2(x2_q);
                        if (cnt_q == CW'(LEN - 1)) begin
                            state_d = IDLE;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Output sample is registered from the next LFSR state, so it only changes
    // when the LFSRs move: stalls keep tdata/tlast stable for free.
    logic [1:0]         c_d;
    logic [1:0][HW-1:0] sym_d;
    assign c_d = x1_d[1:0] ^ x2_d[1:0];

    // lane 0 = I from c(2m), lane 1 = Q from c(2m+1); bit 1 maps to -AMP
    for (genvar l = 0; l < 2; l++) begin : g_lane
        assign sym_d[l] = c_d[l] ? AMP_N : AMP_P;
    end

    always_comb begin
        tvalid_d = (state_d == RUN);
        tlast_d  = tvalid_d && (cnt_d == CW'(LEN - 1));
        tdata_d  = tvalid_d ? sym_d : '0;
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q  <= IDLE;
            x1_q     <= '0;
            x2_q     <= '0;
            cnt_q    <= '0;
            warm_q   <= '0;
            cinit_q  <= '0;
            tdata_q  <= '0;
            tvalid_q <= 1'b0;
            tlast_q  <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            x1_q     <= x1_d;
            x2_q     <= x2_d;
            cnt_q    <= cnt_d;
            warm_q   <= warm_d;
            cinit_q  <= cinit_d;
            tdata_q  <= tdata_d;
            tvalid_q <= tvalid_d;
            tlast_q  <= tlast_d;
            busy_q   <= (state_d != IDLE);
        end
    end

    assign m_axis_out.tdata  = tdata_q;
    assign m_axis_out.tvalid = tvalid_q;
    assign m_axis_out.tlast  = tlast_q;
    assign busy_o            = busy_q;
    assign c_init_o          = cinit_q;
endmodule
